memo_apply_ctrl: RTL
====================

Name: memo_apply_ctrl

Overview:
Sequencer that sits between the core's region-start detector and the memoization lookup unit. It accepts a region-start event, issues one lookup, and on a hit replays the memoized register writes one per accepted cycle through a single regfile write port. It then issues a PC redirect to the memoized next_pc. On a miss, or with memoization disabled, it reports a miss so the core executes the region normally.

Parameters:
MAX_WRITES, 3, register writes per memo entry; must match the lookup unit.
CNT_W, 32, width of statistics counters (used only with MEMO_APPLY_STATS_EN).

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  synchronous active-high reset.
memo_enable  in  1  global memoization enable, sampled at start accept.
start_valid  in  1  region-start request.
start_pc  in  32  region start PC.
start_ready  out  1  high only in IDLE.
lk_req_valid  out  1  lookup request to the lookup unit.
lk_start_pc  out  32  latched start_pc, driven during lookup.
lk_hit  in  1  combinational lookup response.
lk_next_pc  in  32  memoized next PC.
lk_wr_mask  in  MAX_WRITES  valid write slots.
lk_wr_ids  in  5*MAX_WRITES  flattened dest reg ids; slot k is bits [5k+4:5k].
lk_wr_vals  in  32*MAX_WRITES  flattened write values; slot k is bits [32k+31:32k].
rf_we  out  1  regfile write request.
rf_waddr  out  5  write address.
rf_wdata  out  32  write data.
rf_wready  in  1  regfile accepts the write this cycle.
redir_valid  out  1  PC redirect request.
redir_pc  out  32  redirect target.
redir_ready  in  1  fetch accepts the redirect.
done_valid  out  1  one-cycle completion pulse.
done_hit  out  1  qualifies done_valid: 1 = memoized, 0 = execute normally.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset:
  - State goes to IDLE.
  - Latched pc, mask, ids, vals and next_pc are cleared.
  - All outputs are 0 except start_ready=1.
  - Reset in any state aborts the operation immediately. No partial write or redirect is issued after reset.
- States: IDLE, LOOKUP, WRITE, REDIRECT, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid, latch start_pc and memo_enable, then go to LOOKUP.
- LOOKUP (exactly 1 cycle):
  - lk_req_valid=1 and lk_start_pc=latched pc.
  - lk_* responses are sampled in the same cycle.
  - If latched enable=0, or lk_hit=0: go to DONE with done_hit=0. Nothing else is latched.
  - If hit: latch lk_next_pc, lk_wr_mask (into a pending mask), lk_wr_ids and lk_wr_vals.
  - After a hit, go to WRITE if the mask is nonzero, else REDIRECT.
  - lk_req_valid is 0 in every other state.
- WRITE:
  - Select the lowest-indexed pending slot k.
  - If ids[k]==0, the write to x0 is discarded: clear bit k this cycle with rf_we=0.
  - Otherwise, drive rf_we=1, rf_waddr=ids[k], rf_wdata=vals[k], held stable until rf_wready.
  - Bit k clears on the cycle rf_we && rf_wready.
  - When the last pending bit clears, go to REDIRECT the next cycle.
  - Writes are issued strictly in ascending slot order, at most one per cycle.
- REDIRECT:
  - redir_valid=1 and redir_pc=latched next_pc, held until redir_ready.
  - On the handshake, go to DONE.
- DONE:
  - done_valid=1 for exactly one cycle, with done_hit=1 for the hit path and 0 for the miss path.
  - Then go to IDLE.
  - start_ready stays 0 in DONE, so back-to-back requests are spaced by at least 1 cycle.
- Latency, hit with N nonzero-id writes and always-ready sinks:
  - Accept cycle T.
  - LOOKUP at T+1.
  - Writes at T+2 .. T+1+N.
  - REDIRECT at T+2+N.
  - done_valid at T+3+N.
- Latency, miss: done_valid at T+2.
- memo_enable changes after accept have no effect on the operation in flight.
- start_valid outside IDLE is ignored; it is not queued.

Optional Feature:
Macro: MEMO_APPLY_STATS_EN.
- When defined, add outputs:
  - stat_hits (CNT_W): increments on a done_valid pulse with done_hit=1.
  - stat_misses (CNT_W): increments on a done_valid pulse with done_hit=0.
  - stat_writes (CNT_W): increments on each rf_we&&rf_wready.
- All counters saturate at all-ones and are cleared by rst.
- When undefined, these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Hit, single write: bench instantiates the lookup unit with entry 0 (ra=0x2000, a0=5, a1=0); sinks always ready; start_pc=0x1000 accepted at T -> rf_we at T+2 with waddr=10, wdata=12; redir_pc=0x2000 at T+3; done_valid/done_hit=1 at T+4.
- Hit, two writes with backpressure: entry 1 (ra=0x4000, a0=3, a1=9), start_pc=0x3000, rf_wready low for 2 cycles -> x10=42 held stable 3 cycles, then x11=77; redir_pc=0x4000; done_hit=1.
- Miss: start_pc=0x1000 with a0=6 -> no rf_we, no redir_valid; done_valid with done_hit=0 at T+2.
- Disabled: memo_enable=0 with entry 0 context -> done_hit=0 at T+2; memo_enable rising during LOOKUP has no effect.
- x0 write and redirect stall: stubbed response mask=3'b011, ids={5,0} -> only slot 0 writes x5, slot 1 discarded in 1 cycle; redir_ready low 3 cycles keeps redir_pc stable.
- Reset mid-WRITE with rf_wready=0: rst for 1 cycle -> next cycle all outputs 0, start_ready=1; a new start completes normally.

Source files
------------

// File: rtl/memo_apply_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : memo_apply_ctrl
// Function : Region-start sequencer that looks up a memo entry, replays its
//            register writes through one regfile port, then redirects the PC.
//            Optional statistics counters under MEMO_APPLY_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module memo_apply_ctrl #(
    parameter int MAX_WRITES = 3,
    parameter int CNT_W      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    memo_enable,
    input  logic                    start_valid,
    input  logic [31:0]             start_pc,
    output logic                    start_ready,
    output logic                    lk_req_valid,
    output logic [31:0]             lk_start_pc,
    input  logic                    lk_hit,
    input  logic [31:0]             lk_next_pc,
    input  logic [MAX_WRITES-1:0]   lk_wr_mask,
    input  logic [5*MAX_WRITES-1:0] lk_wr_ids,
    input  logic [32*MAX_WRITES-1:0] lk_wr_vals,
    output logic                    rf_we,
    output logic [4:0]              rf_waddr,
    output logic [31:0]             rf_wdata,
    input  logic                    rf_wready,
    output logic                    redir_valid,
    output logic [31:0]             redir_pc,
    input  logic                    redir_ready,
    output logic                    done_valid,
    output logic                    done_hit,
    output logic                    busy
`ifdef MEMO_APPLY_STATS_EN
    ,
    output logic [CNT_W-1:0]        stat_hits,
    output logic [CNT_W-1:0]        stat_misses,
    output logic [CNT_W-1:0]        stat_writes
`endif
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOKUP   = 3'd1,
        S_WRITE    = 3'd2,
        S_REDIRECT = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    if (CNT_W < 1 || MAX_WRITES < 1) begin : g_param_chk
        $error("memo_apply_ctrl: CNT_W and MAX_WRITES must be at least 1");
    end

    state_t                   r_state;
    state_t                   w_state_n;
    logic [31:0]              r_pc;
    logic                     r_en;
    logic                     r_hit;
    logic [31:0]              r_next_pc;
    logic [MAX_WRITES-1:0]    r_mask;
    logic [5*MAX_WRITES-1:0]  r_ids;
    logic [32*MAX_WRITES-1:0] r_vals;

    logic [MAX_WRITES-1:0]    w_low;
    logic                     w_found;
    logic [4:0]               w_slot_id;
    logic [31:0]              w_slot_val;
    logic [MAX_WRITES-1:0]    w_mask_n;

    // One-hot of the lowest pending slot and its id/value.
    always_comb begin
        w_low      = '0;
        w_found    = 1'b0;
        w_slot_id  = '0;
        w_slot_val = '0;
        for (int k = 0; k < MAX_WRITES; k++) begin
            if (r_mask[k] && !w_found) begin
                w_low[k] = 1'b1;
                w_found  = 1'b1;
            end
        end
        for (int k = 0; k < MAX_WRITES; k++) begin
            if (w_low[k]) begin
                w_slot_id  = w_slot_id  | r_ids[5*k +: 5];
                w_slot_val = w_slot_val | r_vals[32*k +: 32];
            end
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_mask_n     = r_mask;
        start_ready  = 1'b0;
        lk_req_valid = 1'b0;
        lk_start_pc  = '0;
        rf_we        = 1'b0;
        rf_waddr     = '0;
        rf_wdata     = '0;
        redir_valid  = 1'b0;
        redir_pc     = '0;
        done_valid   = 1'b0;
        done_hit     = 1'b0;
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    w_state_n = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                lk_req_valid = 1'b1;
                lk_start_pc  = r_pc;
                if (r_en && lk_hit) begin
                    w_state_n = (lk_wr_mask != '0) ? S_WRITE : S_REDIRECT;
                end else begin
                    w_state_n = S_DONE;
                end
            end
            S_WRITE: begin
                // Writes to x0 are dropped without touching the regfile port.
                if (w_slot_id == 5'd0) begin
                    w_mask_n = r_mask & ~w_low;
                end else begin
                    rf_we    = 1'b1;
                    rf_waddr = w_slot_id;
                    rf_wdata = w_slot_val;
                    if (rf_wready) begin
                        w_mask_n = r_mask & ~w_low;
                    end
                end
                if (w_mask_n == '0) begin
                    w_state_n = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                redir_valid = 1'b1;
                redir_pc    = r_next_pc;
                if (redir_ready) begin
                    w_state_n = S_DONE;
                end
            end
            S_DONE: begin
                done_valid = 1'b1;
                done_hit   = r_hit;
                w_state_n  = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_en      <= 1'b0;
            r_hit     <= 1'b0;
            r_next_pc <= '0;
            r_mask    <= '0;
            r_ids     <= '0;
            r_vals    <= '0;
        end else begin
            r_state <= w_state_n;
            if (r_state == S_IDLE && start_valid) begin
                r_pc  <= start_pc;
                r_en  <= memo_enable;
                r_hit <= 1'b0;
            end
            if (r_state == S_LOOKUP && r_en && lk_hit) begin
                r_hit     <= 1'b1;
                r_next_pc <= lk_next_pc;
                r_mask    <= lk_wr_mask;
                r_ids     <= lk_wr_ids;
                r_vals    <= lk_wr_vals;
            end
            if (r_state == S_WRITE) begin
                r_mask <= w_mask_n;
            end
        end
    end

`ifdef MEMO_APPLY_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
            stat_writes <= '0;
        end else begin
            if (done_valid && done_hit && stat_hits != '1) begin
                stat_hits <= stat_hits + CNT_W'(1);
            end
            if (done_valid && !done_hit && stat_misses != '1) begin
                stat_misses <= stat_misses + CNT_W'(1);
            end
            if (rf_we && rf_wready && stat_writes != '1) begin
                stat_writes <= stat_writes + CNT_W'(1);
            end
        end
    end
`endif

endmodule
`default_nettype wire
